// File: rtl/display_pkg.sv
// Shared types and helpers for the display shift-register transmitter.
// State encodings, default frame width and serial half-period computation.
package display_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLK_LO,
    CLK_HI,
    LATCH,
    DONE
  } state_t;

  localparam int DEFAULT_SHIFT_WIDTH = 48;

  // Half serial-clock period in system clocks, never less than one.
  function automatic int calc_half(input int sys_clk_hz, input int shift_clk_hz);
    int h;
    h = sys_clk_hz / (2 * shift_clk_hz);
    if (h < 1) h = 1;
    return h;
  endfunction

endpackage

// File: rtl/shift_clk_divider.sv
// Half-period tick generator: one-cycle o_tick every H cycles while i_run is high.
// Count is held at zero while idle, so each run starts a fresh full half-period.
module shift_clk_divider #(
  parameter int H = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  output logic o_tick
);

  localparam int CW = $clog2(H + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_end;

  assign at_end = (cnt_q == CW'(H - 1));
  assign o_tick = i_run && at_end;

  always_comb begin
    cnt_d = cnt_q;
    if (!i_run || at_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_shift_tx.sv
// Serial frame transmitter: MSB-first on o_serial_data/o_serial_clk, then one latch strobe.
// Frame takes 2*H*SHIFT_WIDTH+H busy cycles; DISPLAY_SHIFT_TX_DOUBLE_BUFFER_EN adds a one-frame pending buffer.
module display_shift_tx
  import display_pkg::*;
#(
  parameter int SYS_CLK_HZ   = 5_000_000,
  parameter int SHIFT_CLK_HZ = 1_000_000,
  parameter int SHIFT_WIDTH  = DEFAULT_SHIFT_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [SHIFT_WIDTH-1:0] i_data,
  input  logic                   i_start,
  output logic                   o_ready,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_serial_data,
  output logic                   o_serial_clk,
  output logic                   o_serial_latch
);

  localparam int H   = calc_half(SYS_CLK_HZ, SHIFT_CLK_HZ);
  localparam int BCW = $clog2(SHIFT_WIDTH + 1);

  state_t                 state_q, state_d;
  logic [SHIFT_WIDTH-1:0] sreg_q, sreg_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   sdata_q, sdata_d;
  logic                   sclk_q, sclk_d;
  logic                   latch_q, latch_d;

`ifdef DISPLAY_SHIFT_TX_DOUBLE_BUFFER_EN
  logic                   pend_vld_q, pend_vld_d;
  logic [SHIFT_WIDTH-1:0] pend_dat_q, pend_dat_d;
`endif

  logic run;
  logic tick;
  logic accept;

  assign run    = (state_q == CLK_LO) || (state_q == CLK_HI) || (state_q == LATCH);
  assign accept = i_start && ready_q;

  shift_clk_divider #(
    .H(H)
  ) u_div (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_run  (run),
    .o_tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
`ifdef DISPLAY_SHIFT_TX_DOUBLE_BUFFER_EN
    pend_vld_d = pend_vld_q;
    pend_dat_d = pend_dat_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
`ifdef DISPLAY_SHIFT_TX_DOUBLE_BUFFER_EN
        if (pend_vld_q) begin
          sreg_d     = pend_dat_q;
          bit_cnt_d  = '0;
          pend_vld_d = 1'b0;
          state_d    = CLK_LO;
        end else
`endif
        if (accept) begin
          sreg_d    = i_data;
          bit_cnt_d = '0;
          state_d   = CLK_LO;
        end
      end
      CLK_LO: begin
        if (tick) state_d = CLK_HI;
      end
      CLK_HI: begin
        // Shift on the falling edge so data only moves while the serial clock is low.
        if (tick) begin
          sreg_d    = {sreg_q[SHIFT_WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = (bit_cnt_q == BCW'(SHIFT_WIDTH - 1)) ? LATCH : CLK_LO;
        end
      end
      LATCH: begin
        if (tick) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

`ifdef DISPLAY_SHIFT_TX_DOUBLE_BUFFER_EN
    if (run && accept) begin
      pend_vld_d = 1'b1;
      pend_dat_d = i_data;
    end
`endif

    // Outputs are decoded from the next state so they leave the block registered.
    busy_d  = (state_d == CLK_LO) || (state_d == CLK_HI) || (state_d == LATCH);
    done_d  = (state_d == DONE);
    sclk_d  = (state_d == CLK_HI);
    latch_d = (state_d == LATCH);
    sdata_d = ((state_d == CLK_LO) || (state_d == CLK_HI)) ? sreg_d[SHIFT_WIDTH-1] : 1'b0;
`ifdef DISPLAY_SHIFT_TX_DOUBLE_BUFFER_EN
    ready_d = !pend_vld_d;
`else
    ready_d = (state_d == IDLE) || (state_d == DONE);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sdata_q   <= 1'b0;
      sclk_q    <= 1'b0;
      latch_q   <= 1'b0;
`ifdef DISPLAY_SHIFT_TX_DOUBLE_BUFFER_EN
      pend_vld_q <= 1'b0;
      pend_dat_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sdata_q   <= sdata_d;
      sclk_q    <= sclk_d;
      latch_q   <= latch_d;
`ifdef DISPLAY_SHIFT_TX_DOUBLE_BUFFER_EN
      pend_vld_q <= pend_vld_d;
      pend_dat_q <= pend_dat_d;
`endif
    end
  end

  assign o_ready        = ready_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_serial_data  = sdata_q;
  assign o_serial_clk   = sclk_q;
  assign o_serial_latch = latch_q;

endmodule

// File: tb/tb_display_shift_tx.sv
// Bench for display_shift_tx: default-rate instance plus an H=1 instance, each feeding a
// shift-register/latch receiver model whose latched words are matched against a scoreboard.
module tb_display_shift_tx;

  localparam int W = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] data0, data1;
  logic         start0, start1;
  logic         ready0, busy0, done0, sd0, sc0, sl0;
  logic         ready1, busy1, done1, sd1, sc1, sl1;

  display_shift_tx #(
    .SYS_CLK_HZ  (5_000_000),
    .SHIFT_CLK_HZ(1_000_000),
    .SHIFT_WIDTH (W)
  ) u_dut0 (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_data        (data0),
    .i_start       (start0),
    .o_ready       (ready0),
    .o_busy        (busy0),
    .o_done        (done0),
    .o_serial_data (sd0),
    .o_serial_clk  (sc0),
    .o_serial_latch(sl0)
  );

  display_shift_tx #(
    .SYS_CLK_HZ  (2_000_000),
    .SHIFT_CLK_HZ(1_000_000),
    .SHIFT_WIDTH (W)
  ) u_dut1 (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_data        (data1),
    .i_start       (start1),
    .o_ready       (ready1),
    .o_busy        (busy1),
    .o_done        (done1),
    .o_serial_data (sd1),
    .o_serial_clk  (sc1),
    .o_serial_latch(sl1)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];

  logic [W-1:0] rx_sh0 = '0, rx_par0 = '0, rx_sh1 = '0, rx_par1 = '0;
  logic [W-1:0] exp0_v, exp1_v;
  logic sc0_p = 1'b0, sl0_p = 1'b0, sc1_p = 1'b0, sl1_p = 1'b0;
  int sclk_rises0 = 0, latch_rises0 = 0, busy_cyc0 = 0;
  int sclk_rises1 = 0, latch_rises1 = 0, busy_cyc1 = 0;
  int last_rise1 = 0, rise_gap1 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver models: shift on serial clock rise, load parallel register on latch rise.
  always @(negedge clk) begin
    if (busy0) busy_cyc0++;
    if (sc0 && !sc0_p) begin
      sclk_rises0++;
      rx_sh0 = {rx_sh0[W-2:0], sd0};
    end
    if (sl0 && !sl0_p) begin
      latch_rises0++;
      rx_par0 = rx_sh0;
      check("dut0_latch_expected", 64'(exp0_q.size() != 0), 64'd1);
      if (exp0_q.size() != 0) begin
        exp0_v = exp0_q.pop_front();
        check("dut0_latched_frame", 64'(rx_par0), 64'(exp0_v));
      end
    end
    sc0_p = sc0;
    sl0_p = sl0;

    if (busy1) busy_cyc1++;
    if (sc1 && !sc1_p) begin
      sclk_rises1++;
      rise_gap1  = cyc - last_rise1;
      last_rise1 = cyc;
      rx_sh1 = {rx_sh1[W-2:0], sd1};
    end
    if (sl1 && !sl1_p) begin
      latch_rises1++;
      rx_par1 = rx_sh1;
      check("dut1_latch_expected", 64'(exp1_q.size() != 0), 64'd1);
      if (exp1_q.size() != 0) begin
        exp1_v = exp1_q.pop_front();
        check("dut1_latched_frame", 64'(rx_par1), 64'(exp1_v));
      end
    end
    sc1_p = sc1;
    sl1_p = sl1;
  end

  task automatic wait_done(input int sel, input int k, output int off);
    off = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if ((sel == 0) ? done0 : done1) begin
        off = cyc - k;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, k2, off, base_r, base_l, base_b, act, d1_cyc, rise20;

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; data0 = '0; data1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(ready0), 64'd1);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_done", 64'(done0), 64'd0);
    check("rst_sclk", 64'(sc0), 64'd0);
    check("rst_latch", 64'(sl0), 64'd0);
    check("rst_sdata", 64'(sd0), 64'd0);
    check("rst_ready_h1", 64'(ready1), 64'd1);

    act = sclk_rises0 + latch_rises0 + busy_cyc0;
    repeat (50) @(negedge clk);
    check("idle_no_activity", 64'(sclk_rises0 + latch_rises0 + busy_cyc0 - act), 64'd0);

    // Frame A on the default-rate instance.
    base_r = sclk_rises0; base_l = latch_rises0; base_b = busy_cyc0;
    data0 = 48'hA55AF00FC33C; start0 = 1'b1; exp0_q.push_back(48'hA55AF00FC33C);
    k = cyc + 1;
    @(negedge clk);
    start0 = 1'b0; data0 = '0;
    check("a_busy_after_accept", 64'(busy0), 64'd1);
    check("a_first_bit_msb", 64'(sd0), 64'd1);

`ifdef DISPLAY_SHIFT_TX_DOUBLE_BUFFER_EN
    repeat (9) @(negedge clk);
    check("db_ready_while_busy", 64'(ready0), 64'd1);
    data0 = 48'h123456789ABC; start0 = 1'b1; exp0_q.push_back(48'h123456789ABC);
    @(negedge clk);
    start0 = 1'b0; data0 = '0;
    check("db_ready_low_pending", 64'(ready0), 64'd0);
    wait_done(0, k, off);
    check("a_done_latency", 64'(off), 64'd194);
    check("a_sclk_rises", 64'(sclk_rises0 - base_r), 64'd48);
    check("a_latch_rises", 64'(latch_rises0 - base_l), 64'd1);
    check("a_busy_cycles", 64'(busy_cyc0 - base_b), 64'd194);
    check("db_ready_after_b_start", 64'(ready0), 64'd1);
    d1_cyc = cyc;
    @(negedge clk);
    check("db_b_no_gap", 64'(busy0), 64'd1);
    wait_done(0, d1_cyc, off);
    check("db_done_gap", 64'(off), 64'd195);
    check("db_sclk_rises", 64'(sclk_rises0 - base_r), 64'd96);
    check("db_latch_rises", 64'(latch_rises0 - base_l), 64'd2);
    check("db_b_latched", 64'(rx_par0), 64'(48'h123456789ABC));
`else
    repeat (20) @(negedge clk);
    check("busy_ready_low", 64'(ready0), 64'd0);
    data0 = '0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0, k, off);
    check("a_done_latency", 64'(off), 64'd194);
    check("a_sclk_rises", 64'(sclk_rises0 - base_r), 64'd48);
    check("a_latch_rises", 64'(latch_rises0 - base_l), 64'd1);
    check("a_busy_cycles", 64'(busy_cyc0 - base_b), 64'd194);
    check("a_latched_value", 64'(rx_par0), 64'(48'hA55AF00FC33C));
    check("done_cycle_ready", 64'(ready0), 64'd1);
    data0 = 48'h123456789ABC; start0 = 1'b1; exp0_q.push_back(48'h123456789ABC);
    k2 = cyc + 1;
    @(negedge clk);
    start0 = 1'b0; data0 = '0;
    check("b_no_gap_busy", 64'(busy0), 64'd1);
    wait_done(0, k2, off);
    check("b_done_latency", 64'(off), 64'd194);
    check("b_latched_value", 64'(rx_par0), 64'(48'h123456789ABC));
`endif

    // Mid-frame reset: frame must be abandoned without a latch strobe.
    base_r = sclk_rises0; base_l = latch_rises0;
    data0 = 48'hFFFF0000FFFF; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; data0 = '0;
    rise20 = 0;
    for (int i = 0; i < 1000; i++) begin
      if (sclk_rises0 - base_r >= 20) begin
        rise20 = 1;
        break;
      end
      @(negedge clk);
    end
    check("reset_reached_20_rises", 64'(rise20), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", 64'(ready0), 64'd1);
    check("mid_rst_busy", 64'(busy0), 64'd0);
    check("mid_rst_done", 64'(done0), 64'd0);
    check("mid_rst_sclk", 64'(sc0), 64'd0);
    check("mid_rst_latch", 64'(sl0), 64'd0);
    check("mid_rst_sdata", 64'(sd0), 64'd0);
    repeat (30) @(negedge clk);
    check("mid_rst_no_latch", 64'(latch_rises0 - base_l), 64'd0);
    check("mid_rst_par_kept", 64'(rx_par0), 64'(48'h123456789ABC));
    check("mid_rst_idle_busy", 64'(busy0), 64'd0);

    // H = 1 instance.
    base_r = sclk_rises1; base_l = latch_rises1; base_b = busy_cyc1;
    data1 = 48'hDEADBEEFCAFE; start1 = 1'b1; exp1_q.push_back(48'hDEADBEEFCAFE);
    k = cyc + 1;
    @(negedge clk);
    start1 = 1'b0; data1 = '0;
    wait_done(1, k, off);
    check("h1_done_latency", 64'(off), 64'd97);
    check("h1_busy_cycles", 64'(busy_cyc1 - base_b), 64'd97);
    check("h1_sclk_rises", 64'(sclk_rises1 - base_r), 64'd48);
    check("h1_sclk_period", 64'(rise_gap1), 64'd2);
    check("h1_latch_rises", 64'(latch_rises1 - base_l), 64'd1);
    check("h1_latched_value", 64'(rx_par1), 64'(48'hDEADBEEFCAFE));

    repeat (5) @(negedge clk);
    check("scoreboard0_drained", 64'(exp0_q.size()), 64'd0);
    check("scoreboard1_drained", 64'(exp1_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
